param_sync_fifo: RTL and testbench

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_mem.sv | 39 +++
 rtl/param_sync_fifo.sv | 135 +++++++++++++
 tb/tb_param_sync_fifo.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and status bundle for the parameterised synchronous FIFO.
package fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_DEPTH      = 256;
    localparam int unsigned STAT_CNT_W     = 32;

    typedef struct packed {
        logic                  full;
        logic                  empty;
        logic                  almost_full;
        logic                  almost_empty;
        logic [STAT_CNT_W-1:0] count;
    } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: one write port, one registered read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Output register resets and holds, the array itself does not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, registered status and error flags.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned AF_LEVEL   = DEPTH - 4,
    parameter int unsigned AE_LEVEL   = 4,
    localparam int unsigned AW        = $clog2(DEPTH),
    localparam int unsigned CW        = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  write_error,
    output logic                  read_error,
    output logic                  overflow_sticky,
    output logic                  underflow_sticky
);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 4");
    end

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, empty_q, af_q, ae_q;
    logic          rd_valid_q, wr_err_q, rd_err_q;
    logic          ovf_q, udf_q;
    logic          wr_acc, rd_acc, wr_err, rd_err;
    fifo_status_t  stat_d;

    always_comb begin
        rd_acc   = ~clr & r_en & ~empty_q;
        wr_acc   = ~clr & w_en & (~full_q | rd_acc);
        wr_err   = ~clr & w_en & full_q & ~rd_acc;
        rd_err   = ~clr & r_en & empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        // Status is derived from next-state so flags move with the pointers.
        stat_d              = '0;
        stat_d.count        = STAT_CNT_W'(count_d);
        stat_d.full         = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0])
                            && (wr_ptr_d[AW] != rd_ptr_d[AW]);
        stat_d.empty        = (wr_ptr_d == rd_ptr_d);
        stat_d.almost_full  = (stat_d.count >= AF_LEVEL);
        stat_d.almost_empty = (stat_d.count <= AE_LEVEL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
            rd_valid_q <= 1'b0;
            wr_err_q   <= 1'b0;
            rd_err_q   <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= stat_d.full;
            empty_q    <= stat_d.empty;
            af_q       <= stat_d.almost_full;
            ae_q       <= stat_d.almost_empty;
            rd_valid_q <= rd_acc;
            wr_err_q   <= wr_err;
            rd_err_q   <= rd_err;
            if (clr) begin
                ovf_q <= 1'b0;
                udf_q <= 1'b0;
            end else begin
                ovf_q <= ovf_q | wr_err;
                udf_q <= udf_q | rd_err;
            end
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (data_in),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (data_out)
    );

    assign rd_valid         = rd_valid_q;
    assign full             = full_q;
    assign empty            = empty_q;
    assign almost_full      = af_q;
    assign almost_empty     = ae_q;
    assign count            = count_q;
    assign write_error      = wr_err_q;
    assign read_error       = rd_err_q;
    assign overflow_sticky  = ovf_q;
    assign underflow_sticky = udf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed self-checking bench for param_sync_fifo at default parameters.
module tb_param_sync_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       clr, w_en, r_en;
    logic [7:0] data_in, data_out;
    logic       rd_valid, full, empty, almost_full, almost_empty;
    logic [8:0] count;
    logic       write_error, read_error, overflow_sticky, underflow_sticky;

    int checks = 0;
    int errors = 0;

    param_sync_fifo dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .clr              (clr),
        .w_en             (w_en),
        .data_in          (data_in),
        .r_en             (r_en),
        .data_out         (data_out),
        .rd_valid         (rd_valid),
        .full             (full),
        .empty            (empty),
        .almost_full      (almost_full),
        .almost_empty     (almost_empty),
        .count            (count),
        .write_error      (write_error),
        .read_error       (read_error),
        .overflow_sticky  (overflow_sticky),
        .underflow_sticky (underflow_sticky)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        logic [15:0] got;
        got = {data_out, rd_valid, full, empty, almost_full, almost_empty,
               write_error, read_error, overflow_sticky};
        checks++;
        if (got !== 16'b0000_0000_0010_1000 || count !== 9'd0
            || underflow_sticky !== 1'b0) begin
            errors++;
            $display("FAIL %s got flags=%b count=%0d udf=%b exp flags=0000000000101000 count=0 udf=0",
                     tag, got, count, underflow_sticky);
        end
    endtask

    task automatic test_reset;
        clr = 0; w_en = 0; r_en = 0; data_in = 0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_async");
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        check_reset_outputs("reset_idle");
    endtask

    task automatic test_fill;
        w_en = 1;
        for (int i = 0; i < 256; i++) begin
            data_in = 8'(i);
            tick;
            checks++;
            if (count !== 9'(i + 1) || full !== (i == 255) || empty !== 1'b0
                || almost_full !== (i + 1 >= 252)
                || almost_empty !== (i + 1 <= 4)
                || write_error !== 1'b0) begin
                errors++;
                $display("FAIL fill n=%0d got cnt=%0d f=%b e=%b af=%b ae=%b we=%b exp cnt=%0d f=%b af=%b ae=%b",
                         i + 1, count, full, empty, almost_full, almost_empty,
                         write_error, i + 1, i == 255, i + 1 >= 252, i + 1 <= 4);
            end
        end
        w_en = 0;
    endtask

    task automatic test_overflow;
        w_en = 1;
        data_in = 8'hAA;
        tick;
        checks++;
        if (write_error !== 1'b1 || overflow_sticky !== 1'b1
            || count !== 9'd256 || full !== 1'b1) begin
            errors++;
            $display("FAIL overflow got we=%b ovf=%b cnt=%0d f=%b exp we=1 ovf=1 cnt=256 f=1",
                     write_error, overflow_sticky, count, full);
        end
        w_en = 0;
        tick;
        checks++;
        if (write_error !== 1'b0 || overflow_sticky !== 1'b1 || count !== 9'd256) begin
            errors++;
            $display("FAIL overflow_after got we=%b ovf=%b cnt=%0d exp we=0 ovf=1 cnt=256",
                     write_error, overflow_sticky, count);
        end
    endtask

    task automatic test_drain;
        r_en = 1;
        for (int k = 0; k < 256; k++) begin
            tick;
            checks++;
            if (rd_valid !== 1'b1 || data_out !== 8'(k) || count !== 9'(255 - k)
                || read_error !== 1'b0 || full !== 1'b0) begin
                errors++;
                $display("FAIL drain k=%0d got v=%b d=%0d cnt=%0d re=%b exp v=1 d=%0d cnt=%0d",
                         k, rd_valid, data_out, count, read_error, k & 255, 255 - k);
            end
        end
        checks++;
        if (empty !== 1'b1 || almost_empty !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty got e=%b ae=%b exp 1 1", empty, almost_empty);
        end
        tick;
        checks++;
        if (read_error !== 1'b1 || underflow_sticky !== 1'b1 || rd_valid !== 1'b0
            || data_out !== 8'hFF || count !== 9'd0) begin
            errors++;
            $display("FAIL underflow got re=%b udf=%b v=%b d=%h cnt=%0d exp re=1 udf=1 v=0 d=ff cnt=0",
                     read_error, underflow_sticky, rd_valid, data_out, count);
        end
        r_en = 0;
        tick;
        checks++;
        if (read_error !== 1'b0 || underflow_sticky !== 1'b1 || data_out !== 8'hFF) begin
            errors++;
            $display("FAIL underflow_after got re=%b udf=%b d=%h exp re=0 udf=1 d=ff",
                     read_error, underflow_sticky, data_out);
        end
    endtask

    task automatic test_concurrent;
        logic [7:0] exp;
        w_en = 1;
        for (int i = 0; i < 256; i++) begin
            data_in = 8'(i);
            tick;
        end
        checks++;
        if (full !== 1'b1 || count !== 9'd256) begin
            errors++;
            $display("FAIL refill got f=%b cnt=%0d exp f=1 cnt=256", full, count);
        end
        r_en = 1;
        for (int j = 0; j < 10; j++) begin
            data_in = 8'(100 + j);
            tick;
            checks++;
            if (write_error !== 1'b0 || count !== 9'd256 || full !== 1'b1
                || rd_valid !== 1'b1 || data_out !== 8'(j)) begin
                errors++;
                $display("FAIL concur j=%0d got we=%b cnt=%0d f=%b v=%b d=%0d exp we=0 cnt=256 f=1 v=1 d=%0d",
                         j, write_error, count, full, rd_valid, data_out, j);
            end
        end
        w_en = 0;
        for (int k = 0; k < 256; k++) begin
            exp = (k < 246) ? 8'(10 + k) : 8'(100 + k - 246);
            tick;
            checks++;
            if (rd_valid !== 1'b1 || data_out !== exp) begin
                errors++;
                $display("FAIL concur_drain k=%0d got v=%b d=%0d exp v=1 d=%0d",
                         k, rd_valid, data_out, exp);
            end
        end
        r_en = 0;
        checks++;
        if (empty !== 1'b1 || count !== 9'd0) begin
            errors++;
            $display("FAIL concur_empty got e=%b cnt=%0d exp e=1 cnt=0", empty, count);
        end
    endtask

    task automatic test_flush;
        w_en = 1;
        for (int i = 0; i < 100; i++) begin
            data_in = 8'(200 + i);
            tick;
        end
        w_en = 0;
        checks++;
        if (count !== 9'd100 || almost_empty !== 1'b0 || overflow_sticky !== 1'b1
            || underflow_sticky !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre got cnt=%0d ae=%b ovf=%b udf=%b exp cnt=100 ae=0 ovf=1 udf=1",
                     count, almost_empty, overflow_sticky, underflow_sticky);
        end
        clr = 1; w_en = 1; r_en = 1;
        tick;
        checks++;
        if (empty !== 1'b1 || count !== 9'd0 || almost_empty !== 1'b1
            || overflow_sticky !== 1'b0 || underflow_sticky !== 1'b0
            || rd_valid !== 1'b0 || write_error !== 1'b0 || read_error !== 1'b0) begin
            errors++;
            $display("FAIL flush got e=%b cnt=%0d ae=%b ovf=%b udf=%b v=%b we=%b re=%b exp e=1 cnt=0 ae=1 rest 0",
                     empty, count, almost_empty, overflow_sticky, underflow_sticky,
                     rd_valid, write_error, read_error);
        end
        clr = 0; w_en = 0; r_en = 0;
        tick;
        checks++;
        if (empty !== 1'b1 || count !== 9'd0) begin
            errors++;
            $display("FAIL flush_hold got e=%b cnt=%0d exp e=1 cnt=0", empty, count);
        end
    endtask

    task automatic test_midburst_reset;
        w_en = 1;
        for (int i = 0; i < 20; i++) begin
            data_in = 8'(50 + i);
            tick;
        end
        r_en = 1;
        data_in = 8'd77;
        tick;
        checks++;
        if (rd_valid !== 1'b1 || data_out !== 8'd50 || count !== 9'd20) begin
            errors++;
            $display("FAIL burst got v=%b d=%0d cnt=%0d exp v=1 d=50 cnt=20",
                     rd_valid, data_out, count);
        end
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_midburst");
        w_en = 0; r_en = 0;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        check_reset_outputs("reset_release");
    endtask

    initial begin
        test_reset;
        test_fill;
        test_overflow;
        test_drain;
        test_concurrent;
        test_flush;
        test_midburst_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
